// File: rtl/stack_cpu_core.sv
// stack_cpu_core: multicycle zero-address stack machine with a shared memory port,
// hardware operand stack, sticky over/underflow halt, retire strobe and debug taps.
module stack_cpu_core #(
    parameter int WORD_W      = 8,
    parameter int ADDR_W      = 5,
    parameter int STACK_DEPTH = 8,
    parameter int RESET_PC    = 0
) (
    input  logic                               clk,
    input  logic                               rst,
    output logic [ADDR_W-1:0]                  mem_addr,
    output logic                               mem_re,
    output logic                               mem_we,
    output logic [WORD_W-1:0]                  mem_wdata,
    input  logic [WORD_W-1:0]                  mem_rdata,
    output logic                               halted,
    output logic [1:0]                         fault,
    output logic                               retire,
    output logic [ADDR_W-1:0]                  pc,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   sp,
    output logic [WORD_W-1:0]                  tos
);
    localparam int SP_W  = $clog2(STACK_DEPTH+1);
    localparam int IDX_W = $clog2(STACK_DEPTH);
    localparam logic [2:0] OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010, OP_NOT = 3'b011;
    localparam logic [2:0] OP_PUSH = 3'b100, OP_POP = 3'b101, OP_JMP = 3'b110, OP_JZ = 3'b111;

    typedef enum logic [2:0] {S_IF, S_ID, S_POPB, S_EXE, S_MEM, S_HALT} state_t;
    state_t state, state_nx;

    logic [WORD_W-1:0] ir, a, b, alu, push_d;
    logic [WORD_W-1:0] stk [STACK_DEPTH];
    logic [2:0]        opc;
    logic [ADDR_W-1:0] addr;
    logic [SP_W-1:0]   spm1;
    logic              bin, uf, of, push, pop;

    assign opc  = ir[WORD_W-1 -: 3];
    assign addr = ir[ADDR_W-1:0];
    assign spm1 = sp - SP_W'(1);
    assign tos  = (sp == '0) ? '0 : stk[spm1[IDX_W-1:0]];
    assign bin  = (opc == OP_ADD) || (opc == OP_SUB) || (opc == OP_AND);
    // Occupancy checks are decoded from IR so they can veto every ID side effect
    assign uf   = (bin && sp < SP_W'(2)) ||
                  ((opc == OP_NOT || opc == OP_POP || opc == OP_JZ) && sp == '0);
    assign of   = (opc == OP_PUSH) && (sp == SP_W'(STACK_DEPTH));
    assign alu  = (opc == OP_ADD) ? b + a :
                  (opc == OP_SUB) ? b - a :
                  (opc == OP_AND) ? b & a : ~a;
    assign push   = (state == S_EXE) || (state == S_MEM && opc == OP_PUSH);
    assign pop    = (state == S_ID && !uf && (bin || opc == OP_NOT)) || (state == S_POPB) ||
                    (state == S_MEM && opc == OP_POP);
    assign push_d = (state == S_EXE) ? alu : mem_rdata;

    // Strobes are gated by rst so they drop the instant reset is asserted
    assign mem_addr  = (state == S_IF) ? pc : addr;
    assign mem_re    = rst && ((state == S_IF) || (state == S_MEM && opc == OP_PUSH));
    assign mem_we    = rst && (state == S_MEM) && (opc == OP_POP);
    assign mem_wdata = tos;
    assign halted    = (state == S_HALT);
    assign retire    = rst && ((state == S_EXE) || (state == S_MEM) ||
                       (state == S_ID && (opc == OP_JMP || (opc == OP_JZ && !uf))));

    always_comb begin
        state_nx = state;
        case (state)
            S_IF:    state_nx = S_ID;
            S_ID:    state_nx = (uf || of) ? S_HALT :
                                (opc == OP_JMP || opc == OP_JZ) ? S_IF :
                                bin ? S_POPB : (opc == OP_NOT) ? S_EXE : S_MEM;
            S_POPB:  state_nx = S_EXE;
            S_EXE:   state_nx = S_IF;
            S_MEM:   state_nx = S_IF;
            default: state_nx = state;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IF;
            pc    <= ADDR_W'(RESET_PC);
            sp    <= '0;
            ir    <= '0;
            a     <= '0;
            b     <= '0;
            fault <= 2'b00;
        end else begin
            state <= state_nx;
            if (state == S_IF) begin
                ir <= mem_rdata;
                pc <= pc + ADDR_W'(1);
            end
            if (state == S_ID) fault <= uf ? 2'b01 : of ? 2'b10 : 2'b00;
            if (state == S_ID && !uf && !of) begin
                if (opc == OP_JMP || (opc == OP_JZ && tos == '0)) pc <= addr;
                if (bin || opc == OP_NOT) a <= tos;
            end
            if (state == S_POPB) b <= tos;
            if (push) sp <= sp + SP_W'(1);
            else if (pop) sp <= spm1;
        end
    end

    // Stack contents are deliberately not reset; only sp defines validity
    always_ff @(posedge clk) begin
        if (push) stk[sp[IDX_W-1:0]] <= push_d;
    end
endmodule

// File: tb/tb_stack_cpu_core.sv
// tb_stack_cpu_core: scoreboarded bench for stack_cpu_core (default and 16/8/4 builds).
module tb_stack_cpu_core;
    localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND_ = 3'b010, NOT_ = 3'b011;
    localparam logic [2:0] PUSH = 3'b100, POP = 3'b101, JMP = 3'b110, JZ = 3'b111;

    logic clk = 0;
    always #5 clk = ~clk;
    logic rst1 = 0, rst2 = 0;

    logic [4:0]  m1_addr, m1_pc;
    logic        m1_re, m1_we, m1_halted, m1_retire;
    logic [7:0]  m1_wdata, m1_rdata, m1_tos;
    logic [1:0]  m1_fault;
    logic [3:0]  m1_sp;
    logic [7:0]  mem1 [32];

    logic [7:0]  m2_addr, m2_pc;
    logic        m2_re, m2_we, m2_halted, m2_retire;
    logic [15:0] m2_wdata, m2_rdata, m2_tos;
    logic [1:0]  m2_fault;
    logic [2:0]  m2_sp;
    logic [15:0] mem2 [256];

    stack_cpu_core u1 (
        .clk(clk), .rst(rst1), .mem_addr(m1_addr), .mem_re(m1_re), .mem_we(m1_we),
        .mem_wdata(m1_wdata), .mem_rdata(m1_rdata), .halted(m1_halted), .fault(m1_fault),
        .retire(m1_retire), .pc(m1_pc), .sp(m1_sp), .tos(m1_tos));

    stack_cpu_core #(.WORD_W(16), .ADDR_W(8), .STACK_DEPTH(4), .RESET_PC(0)) u2 (
        .clk(clk), .rst(rst2), .mem_addr(m2_addr), .mem_re(m2_re), .mem_we(m2_we),
        .mem_wdata(m2_wdata), .mem_rdata(m2_rdata), .halted(m2_halted), .fault(m2_fault),
        .retire(m2_retire), .pc(m2_pc), .sp(m2_sp), .tos(m2_tos));

    assign m1_rdata = mem1[m1_addr];
    assign m2_rdata = mem2[m2_addr];
    always @(posedge clk) if (m1_we) mem1[m1_addr] <= m1_wdata;
    always @(posedge clk) if (m2_we) mem2[m2_addr] <= m2_wdata;

    int n_run = 0, n_fail = 0, ret = 0, cyc = 0;
    typedef struct { logic [31:0] a; logic [31:0] d; } st_t;
    st_t q1[$], q2[$];
    st_t e1, e2;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Every store the DUT makes must match the next expected store in order
    always @(negedge clk) if (rst1 && m1_we) begin
        if (q1.size() == 0) chk("st1_unexpected", 32'(m1_addr), 32'hFFFF_FFFF);
        else begin
            e1 = q1.pop_front();
            chk("st1_addr", 32'(m1_addr), e1.a);
            chk("st1_data", 32'(m1_wdata), e1.d);
        end
    end
    always @(negedge clk) if (rst2 && m2_we) begin
        if (q2.size() == 0) chk("st2_unexpected", 32'(m2_addr), 32'hFFFF_FFFF);
        else begin
            e2 = q2.pop_front();
            chk("st2_addr", 32'(m2_addr), e2.a);
            chk("st2_data", 32'(m2_wdata), e2.d);
        end
    end

    function automatic logic [7:0] i8(input logic [2:0] o, input int ad);
        return {o, 5'(ad)};
    endfunction
    function automatic logic [15:0] i16(input logic [2:0] o, input int ad);
        return {o, 5'b0, 8'(ad)};
    endfunction

    task automatic hold(input bit s2);
        if (s2) rst2 = 0; else rst1 = 0;
        @(posedge clk); #1;
    endtask
    task automatic release_rst(input bit s2);
        @(posedge clk); #1;
        if (s2) rst2 = 1; else rst1 = 1;
        ret = 0;
        cyc = 0;
    endtask
    task automatic step(input int n, input bit s2);
        repeat (n) begin
            @(negedge clk);
            cyc++;
            if (s2 ? m2_retire : m1_retire) ret++;
        end
    endtask
    task automatic run(input string tag, input int target, input bit s2);
        int g = 0;
        while (ret < target && g < 200) begin
            step(1, s2);
            g++;
        end
        chk(tag, ret, target);
    endtask
    task automatic settle;
        @(posedge clk); #1;
    endtask
    task automatic clear1;
        for (int i = 0; i < 32; i++) mem1[i] = '0;
    endtask
    task automatic load_t1;
        clear1();
        mem1[0] = i8(PUSH, 20); mem1[1] = i8(PUSH, 21); mem1[2] = i8(ADD, 0); mem1[3] = i8(POP, 22);
        mem1[20] = 8'd5; mem1[21] = 8'd7;
    endtask

    initial begin
        // reset state and test 1: 5+7
        hold(0);
        chk("rst_pc", 32'(m1_pc), 0);
        chk("rst_sp", 32'(m1_sp), 0);
        chk("rst_tos", 32'(m1_tos), 0);
        chk("rst_strobes", {m1_re, m1_we, m1_retire, m1_halted}, 0);
        chk("rst_fault", 32'(m1_fault), 0);
        load_t1();
        q1.push_back('{32'd22, 32'd12});
        release_rst(0);
        run("t1_r1", 1, 0);
        chk("t1_lat_push", cyc, 3);
        run("t1_r2", 2, 0);
        settle();
        chk("t1_sp2", 32'(m1_sp), 2);
        chk("t1_tos2", 32'(m1_tos), 7);
        run("t1_r3", 3, 0);
        chk("t1_lat_add", cyc, 10);
        run("t1_r4", 4, 0);
        chk("t1_cycles", cyc, 13);
        settle();
        chk("t1_sp", 32'(m1_sp), 0);
        chk("t1_mem22", 32'(mem1[22]), 12);
        chk("t1_q", q1.size(), 0);

        // test 2: SUB, NOT, ADD wrap, AND
        hold(0);
        clear1();
        mem1[0] = i8(PUSH, 21); mem1[1] = i8(PUSH, 20); mem1[2] = i8(SUB, 0); mem1[3] = i8(POP, 22);
        mem1[4] = i8(PUSH, 24); mem1[5] = i8(NOT_, 0); mem1[6] = i8(POP, 25);
        mem1[7] = i8(PUSH, 26); mem1[8] = i8(PUSH, 27); mem1[9] = i8(ADD, 0); mem1[10] = i8(POP, 28);
        mem1[11] = i8(PUSH, 30); mem1[12] = i8(PUSH, 24); mem1[13] = i8(AND_, 0); mem1[14] = i8(POP, 29);
        mem1[20] = 8'd3; mem1[21] = 8'd10; mem1[24] = 8'h0F; mem1[26] = 8'hFF; mem1[27] = 8'h01;
        mem1[30] = 8'h3C; mem1[28] = 8'hAA;
        q1.push_back('{32'd22, 32'h07});
        q1.push_back('{32'd25, 32'hF0});
        q1.push_back('{32'd28, 32'h00});
        q1.push_back('{32'd29, 32'h0C});
        release_rst(0);
        run("t2_r15", 15, 0);
        settle();
        chk("t2_sp", 32'(m1_sp), 0);
        chk("t2_mem28", 32'(mem1[28]), 0);
        chk("t2_q", q1.size(), 0);

        // test 3: JZ taken/not taken, JMP, PC wrap
        hold(0);
        clear1();
        mem1[0] = i8(PUSH, 20); mem1[1] = i8(JZ, 10); mem1[10] = i8(PUSH, 21); mem1[11] = i8(JZ, 5);
        mem1[12] = i8(JMP, 31); mem1[31] = i8(POP, 23);
        mem1[20] = 8'd0; mem1[21] = 8'd1;
        q1.push_back('{32'd23, 32'd1});
        release_rst(0);
        run("t3_r2", 2, 0);
        chk("t3_lat_jz", cyc, 5);
        settle();
        chk("t3_jz_pc", 32'(m1_pc), 10);
        chk("t3_jz_sp", 32'(m1_sp), 1);
        run("t3_r4", 4, 0);
        settle();
        chk("t3_nojz_pc", 32'(m1_pc), 12);
        chk("t3_nojz_sp", 32'(m1_sp), 2);
        run("t3_r5", 5, 0);
        settle();
        chk("t3_jmp_pc", 32'(m1_pc), 31);
        run("t3_r6", 6, 0);
        chk("t3_wrap_pc", 32'(m1_pc), 0);
        settle();
        chk("t3_sp", 32'(m1_sp), 1);
        chk("t3_q", q1.size(), 0);

        // test 4a: ADD on a single entry underflows
        hold(0);
        clear1();
        mem1[0] = i8(PUSH, 20); mem1[1] = i8(ADD, 0); mem1[20] = 8'd9;
        release_rst(0);
        run("t4_r1", 1, 0);
        step(2, 0);
        chk("t4_id_fault", 32'(m1_fault), 0);
        chk("t4_id_retire", 32'(m1_retire), 0);
        step(1, 0);
        chk("t4_halted", 32'(m1_halted), 1);
        chk("t4_fault_uf", 32'(m1_fault), 1);
        chk("t4_sp", 32'(m1_sp), 1);
        chk("t4_tos", 32'(m1_tos), 9);
        chk("t4_pc", 32'(m1_pc), 2);
        chk("t4_strobes", {m1_re, m1_we, m1_retire}, 0);
        step(3, 0);
        chk("t4_sticky", {m1_halted, m1_fault}, 3'b101);
        chk("t4_noretire", ret, 1);

        // test 4b: ninth PUSH overflows
        hold(0);
        clear1();
        for (int i = 0; i < 9; i++) mem1[i] = i8(PUSH, 20);
        mem1[20] = 8'h5A;
        release_rst(0);
        run("t4b_r8", 8, 0);
        settle();
        chk("t4b_sp8", 32'(m1_sp), 8);
        step(3, 0);
        chk("t4b_halted", 32'(m1_halted), 1);
        chk("t4b_fault_of", 32'(m1_fault), 2);
        chk("t4b_sp", 32'(m1_sp), 8);
        chk("t4b_pc", 32'(m1_pc), 9);
        chk("t4b_ret", ret, 8);

        // test 5: reset during EXE of ADD
        hold(0);
        load_t1();
        q1.push_back('{32'd22, 32'd12});
        release_rst(0);
        run("t5_r2", 2, 0);
        step(4, 0);
        chk("t5_in_exe", ret, 3);
        rst1 = 0;
        #1;
        chk("t5_pc", 32'(m1_pc), 0);
        chk("t5_sp", 32'(m1_sp), 0);
        chk("t5_tos", 32'(m1_tos), 0);
        chk("t5_strobes", {m1_re, m1_we, m1_retire, m1_halted}, 0);
        release_rst(0);
        step(1, 0);
        chk("t5_refetch", {m1_re, 3'b0, m1_addr}, 9'h100);
        run("t5_r4", 4, 0);
        chk("t5_cycles", cyc, 13);
        settle();
        chk("t5_mem22", 32'(mem1[22]), 12);
        chk("t5_q", q1.size(), 0);

        // test 6: 16-bit, 4-deep build
        hold(1);
        chk("t6_rst_pc", 32'(m2_pc), 0);
        for (int i = 0; i < 256; i++) mem2[i] = '0;
        mem2[0] = i16(PUSH, 20); mem2[1] = i16(PUSH, 21); mem2[2] = i16(ADD, 0); mem2[3] = i16(POP, 22);
        for (int i = 4; i < 9; i++) mem2[i] = i16(PUSH, 20);
        mem2[20] = 16'h1234; mem2[21] = 16'hF0F0;
        q2.push_back('{32'd22, 32'h0324});
        release_rst(1);
        run("t6_r4", 4, 1);
        chk("t6_cycles", cyc, 13);
        settle();
        chk("t6_mem22", 32'(mem2[22]), 32'h0324);
        chk("t6_sp0", 32'(m2_sp), 0);
        run("t6_r8", 8, 1);
        settle();
        chk("t6_sp4", 32'(m2_sp), 4);
        chk("t6_tos", 32'(m2_tos), 32'h1234);
        step(3, 1);
        chk("t6_halted", 32'(m2_halted), 1);
        chk("t6_fault_of", 32'(m2_fault), 2);
        chk("t6_pc", 32'(m2_pc), 9);
        chk("t6_ret", ret, 8);
        chk("t6_q", q2.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
